// File: rtl/dadda_nxn_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : dadda_nxn_pipelined
// Description : Pipelined WIDTH x WIDTH Dadda-style multiplier. Partial
//               products (Baugh-Wooley in signed mode) are reduced by one
//               4:2 compressor level (S1), carry-save cleanup to two rows
//               (S2), and a final carry-propagate adder (S3). A valid/ready
//               handshake with full backpressure and a sideband tag are
//               carried alongside the data.
//               Optional macro DADDA_MAC_EN adds in_acc_clr and a 2*WIDTH
//               accumulator stage after S3 (latency 4 instead of 3).
//               WIDTH must be even and in 4..32.
// Revision    : 1.0 - initial release
// ============================================================================
module dadda_nxn_pipelined #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_signed,
   input  logic [TAG_W-1:0]     in_tag,
`ifdef DADDA_MAC_EN
   input  logic                 in_acc_clr,
`endif
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_p,
   output logic [TAG_W-1:0]     out_tag,
   output logic                 busy
);

   localparam int c_pw = 2 * WIDTH;           // product width
   localparam int c_nr = WIDTH + 1;           // PP rows plus the Baugh-Wooley constant row
   localparam int c_ng = c_nr / 4;            // 4:2 compressor groups in the first level
   localparam int c_nl = c_nr % 4;            // rows passed straight through the first level
   localparam int c_r1 = 2 * c_ng + c_nl;     // rows held in S1
   localparam logic [c_pw-1:0] c_one = {{(c_pw-1){1'b0}}, 1'b1};
   // Baugh-Wooley correction: +1 at column WIDTH and at column 2*WIDTH-1
   localparam logic [c_pw-1:0] c_bw_const = (c_one << WIDTH) | (c_one << (c_pw - 1));

   function automatic logic [c_pw-1:0] maj3(input logic [c_pw-1:0] a,
                                             input logic [c_pw-1:0] b,
                                             input logic [c_pw-1:0] c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   logic [c_pw-1:0] w_pp [c_nr];
   logic [c_pw-1:0] w_l1 [c_r1];
   logic            w_bit;
   logic            w_stall;

   logic [c_pw-1:0] s1_rows_q [c_r1];
   logic [TAG_W-1:0] s1_tag_q, s2_tag_q;
   logic            s1_valid_q, s2_valid_q, s3_valid_q;
   logic [c_pw-1:0] s2_sum_d, s2_car_d, s2_sum_q, s2_car_q;
   logic [c_pw-1:0] w_tsum, w_tcar;
   logic [c_pw-1:0] s3_prod_d;
   logic [c_pw-1:0] out_p_q;
   logic [TAG_W-1:0] out_tag_q;

   // Partial-product rows; MSB row/column cross terms are inverted in signed mode
   always_comb begin
      w_bit = 1'b0;
      for (int i = 0; i < c_nr; i++) w_pp[i] = '0;
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            w_bit = in_a[j] & in_b[i];
            if (in_signed && ((i == WIDTH - 1) != (j == WIDTH - 1)))
               w_bit = ~w_bit;
            w_pp[i][i+j] = w_bit;
         end
      end
      w_pp[WIDTH] = in_signed ? c_bw_const : '0;
   end

   // First reduction level: each group of four rows becomes a sum/carry pair
   for (genvar g = 0; g < c_ng; g++) begin : g_cmp42
      logic [c_pw-1:0] w_s0, w_c0;
      assign w_s0          = w_pp[4*g] ^ w_pp[4*g+1] ^ w_pp[4*g+2];
      assign w_c0          = maj3(w_pp[4*g], w_pp[4*g+1], w_pp[4*g+2]) << 1;
      assign w_l1[2*g]     = w_s0 ^ w_c0 ^ w_pp[4*g+3];
      assign w_l1[2*g+1]   = maj3(w_s0, w_c0, w_pp[4*g+3]) << 1;
   end

   for (genvar k = 0; k < c_nl; k++) begin : g_pass
      assign w_l1[2*c_ng+k] = w_pp[4*c_ng+k];
   end

   // FA/HA cleanup: fold the remaining S1 rows down to one sum and one carry row
   always_comb begin
      w_tsum   = '0;
      w_tcar   = '0;
      s2_sum_d = s1_rows_q[0];
      s2_car_d = s1_rows_q[1];
      for (int k = 2; k < c_r1; k++) begin
         w_tsum   = s2_sum_d ^ s2_car_d ^ s1_rows_q[k];
         w_tcar   = maj3(s2_sum_d, s2_car_d, s1_rows_q[k]) << 1;
         s2_sum_d = w_tsum;
         s2_car_d = w_tcar;
      end
   end

   // Final carry-propagate adder; carry out of the top bit is discarded
   assign s3_prod_d = s2_sum_q + s2_car_q;

   assign w_stall  = out_valid && !out_ready;
   assign in_ready = !w_stall;
   assign out_p    = out_p_q;
   assign out_tag  = out_tag_q;

   // S1/S2 datapath registers: no reset, frozen while the output is stalled
   always_ff @(posedge clk) begin
      if (!w_stall) begin
         for (int k = 0; k < c_r1; k++) s1_rows_q[k] <= w_l1[k];
         s1_tag_q <= in_tag;
         s2_sum_q <= s2_sum_d;
         s2_car_q <= s2_car_d;
         s2_tag_q <= s1_tag_q;
      end
   end

`ifdef DADDA_MAC_EN
   logic            s1_clr_q, s2_clr_q, s3_clr_q;
   logic [c_pw-1:0] s3_prod_q;
   logic [TAG_W-1:0] s3_tag_q;
   logic            s4_valid_q;

   assign out_valid = s4_valid_q;
   assign busy      = s1_valid_q | s2_valid_q | s3_valid_q | s4_valid_q;

   // Stage valid bits advance together unless the output is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s3_valid_q <= 1'b0;
         s4_valid_q <= 1'b0;
      end else if (!w_stall) begin
         s1_valid_q <= in_valid;
         s2_valid_q <= s1_valid_q;
         s3_valid_q <= s2_valid_q;
         s4_valid_q <= s3_valid_q;
      end
   end

   // S3 product and the clear flag travelling with each transaction
   always_ff @(posedge clk) begin
      if (!w_stall) begin
         s1_clr_q  <= in_acc_clr;
         s2_clr_q  <= s1_clr_q;
         s3_clr_q  <= s2_clr_q;
         s3_prod_q <= s3_prod_d;
         s3_tag_q  <= s2_tag_q;
      end
   end

   // Accumulator doubles as the output register; updates only on a real transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_p_q   <= '0;
         out_tag_q <= '0;
      end else if (!w_stall && s3_valid_q) begin
         out_p_q   <= s3_clr_q ? s3_prod_q : out_p_q + s3_prod_q;
         out_tag_q <= s3_tag_q;
      end
   end
`else
   assign out_valid = s3_valid_q;
   assign busy      = s1_valid_q | s2_valid_q | s3_valid_q;

   // Stage valid bits advance together unless the output is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s3_valid_q <= 1'b0;
      end else if (!w_stall) begin
         s1_valid_q <= in_valid;
         s2_valid_q <= s1_valid_q;
         s3_valid_q <= s2_valid_q;
      end
   end

   // S3 output register; only loaded by valid transactions so bubbles leave it intact
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_p_q   <= '0;
         out_tag_q <= '0;
      end else if (!w_stall && s2_valid_q) begin
         out_p_q   <= s3_prod_d;
         out_tag_q <= s2_tag_q;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dadda_nxn_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : tb_dadda_nxn_pipelined
// Description : Self-checking bench for dadda_nxn_pipelined (WIDTH=8,
//               TAG_W=4). Directed vectors plus a short alternating-mode
//               burst, backpressure and mid-flight reset scenarios. With
//               DADDA_MAC_EN defined it runs the accumulate sequence instead.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dadda_nxn_pipelined;

   localparam int W     = 8;
   localparam int TW    = 4;
`ifdef DADDA_MAC_EN
   localparam int LAT   = 4;
`else
   localparam int LAT   = 3;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a, in_b;
   logic          in_signed;
   logic [TW-1:0] in_tag;
`ifdef DADDA_MAC_EN
   logic          in_acc_clr;
`endif
   logic          out_valid;
   logic          out_ready;
   logic [2*W-1:0] out_p;
   logic [TW-1:0] out_tag;
   logic          busy;

   typedef struct {
      logic [2*W-1:0] p;
      logic [TW-1:0]  tag;
   } exp_t;

   exp_t           sb_q[$];
   int             n_checks = 0;
   int             n_fail   = 0;
   int             n_recv   = 0;
   int             run_len  = 0;
   int             max_run  = 0;
   logic           held_v   = 1'b0;
   logic [2*W-1:0] held_p;
   logic [TW-1:0]  held_tag;

   dadda_nxn_pipelined #(.WIDTH(W), .TAG_W(TW)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_signed (in_signed),
      .in_tag    (in_tag),
`ifdef DADDA_MAC_EN
      .in_acc_clr(in_acc_clr),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
      end
   endtask

   function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
      logic signed [2*W-1:0] sa, sb;
      logic [2*W-1:0]        ua, ub;
      sa = $signed(a);
      sb = $signed(b);
      ua = {{W{1'b0}}, a};
      ub = {{W{1'b0}}, b};
      return s ? (sa * sb) : (ua * ub);
   endfunction

   // Output monitor: scoreboard compare on transfer, stability check while stalled
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            exp_t e;
            n_recv++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            check("out_has_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check("out_p", 64'(out_p), 64'(e.p));
               check("out_tag", 64'(out_tag), 64'(e.tag));
            end
         end else begin
            run_len = 0;
         end
         if (out_valid && !out_ready) begin
            if (held_v) begin
               check("hold_p", 64'(out_p), 64'(held_p));
               check("hold_tag", 64'(out_tag), 64'(held_tag));
            end
            held_v   = 1'b1;
            held_p   = out_p;
            held_tag = out_tag;
         end else begin
            held_v = 1'b0;
         end
      end
   end

   // Present one transaction and hold it until accepted; returns at posedge+1
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [TW-1:0] tag, input logic [2*W-1:0] want, input logic clr);
      logic accepted;
      accepted  = 1'b0;
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      in_signed = s;
      in_tag    = tag;
`ifdef DADDA_MAC_EN
      in_acc_clr = clr;
`else
      if (clr) in_tag = tag;
`endif
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready) begin
            sb_q.push_back('{p: want, tag: tag});
            accepted = 1'b1;
         end
         @(posedge clk);
         #1;
         if (accepted) break;
      end
      check("send_accepted", 64'(accepted), 64'd1);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
   endtask

   task automatic drain();
      for (int k = 0; k < 100; k++) begin
         if (sb_q.size() == 0 && !busy) break;
         @(posedge clk);
         #1;
      end
      check("drain_empty", 64'(sb_q.size()), 64'd0);
      check("drain_not_busy", 64'(busy), 64'd0);
   endtask

   task automatic measure_latency();
      int lat;
      lat = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         lat++;
         if (out_valid) break;
      end
      @(posedge clk);
      #1;
      check("latency", 64'(lat), 64'(LAT));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int recv0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_signed = 1'b0;
      in_tag    = '0;
`ifdef DADDA_MAC_EN
      in_acc_clr = 1'b0;
`endif
      out_ready = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_out_p", 64'(out_p), 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

`ifdef DADDA_MAC_EN
      // Accumulate: 6, 6+20, 26-1
      send(8'h02, 8'h03, 1'b0, 4'h1, 16'h0006, 1'b1);
      idle();
      measure_latency();
      send(8'h04, 8'h05, 1'b0, 4'h2, 16'h001A, 1'b0);
      send(8'hFF, 8'h01, 1'b1, 4'h3, 16'h0019, 1'b0);
      idle();
      drain();
`else
      // Largest unsigned product and pipeline latency
      send(8'hFF, 8'hFF, 1'b0, 4'h5, 16'hFE01, 1'b0);
      idle();
      measure_latency();
      drain();

      // Signed corner cases and the same operands unsigned, back to back
      send(8'h80, 8'h80, 1'b1, 4'h1, 16'h4000, 1'b0);
      send(8'hFF, 8'h01, 1'b1, 4'h2, 16'hFFFF, 1'b0);
      send(8'h7F, 8'h80, 1'b1, 4'h3, 16'hC080, 1'b0);
      send(8'hFF, 8'h01, 1'b0, 4'h4, 16'h00FF, 1'b0);
      idle();
      drain();

      // Back-to-back burst with alternating mode
      max_run = 0;
      for (int k = 0; k < 8; k++) begin
         logic [W-1:0] a, b;
         a = W'($urandom);
         b = W'($urandom);
         send(a, b, k[0], TW'(k + 8), model(a, b, k[0]), 1'b0);
      end
      idle();
      drain();
      check("burst_consecutive", 64'(max_run), 64'd8);

      // Backpressure with three transactions in flight
      out_ready = 1'b0;
      recv0 = n_recv;
      send(8'h12, 8'h34, 1'b0, 4'hA, 16'h03A8, 1'b0);
      send(8'h9C, 8'h07, 1'b1, 4'hB, 16'hFD44, 1'b0);
      send(8'h55, 8'hAA, 1'b0, 4'hC, 16'h3872, 1'b0);
      idle();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_in_ready", 64'(in_ready), 64'd0);
         @(posedge clk);
         #1;
      end
      check("stall_no_delivery", 64'(n_recv - recv0), 64'd0);
      out_ready = 1'b1;
      drain();
      check("stall_all_delivered", 64'(n_recv - recv0), 64'd3);

      // Asynchronous reset with two transactions in flight
      send(8'h11, 8'h22, 1'b0, 4'h6, 16'h0242, 1'b0);
      send(8'h33, 8'h44, 1'b0, 4'h7, 16'h0D8C, 1'b0);
      idle();
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_out_p", 64'(out_p), 64'd0);
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      recv0 = n_recv;
      repeat (6) begin
         @(posedge clk);
         #1;
      end
      check("post_reset_quiet", 64'(n_recv - recv0), 64'd0);
      send(8'h03, 8'h04, 1'b0, 4'h9, 16'h000C, 1'b0);
      idle();
      drain();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
